adc_frame_reader: RTL and testbench

Parametrised serial ADC front end that frames conversions with an active-low chip select and deserialises WIDTH-bit samples, MSB- or LSB-first. It round-robins a channel select across CHANNELS analog inputs and tags each sample with its channel. Completed samples are buffered in a small FIFO with a valid/ready output. Sits between the ADC pins and the sample-processing pipeline, replacing the fixed 12-bit, free-running shift collector.

---
 rtl/adc_pkg.sv | 20 ++
 rtl/adc_frame_reader_if.sv | 50 +++++
 rtl/adc_sample_fifo.sv | 62 ++++++
 rtl/adc_frame_reader.sv | 171 +++++++++++++++++
 tb/tb_adc_frame_reader.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/adc_pkg.sv
// adc_pkg: shared types and constants for the serial ADC frame reader.
//   adc_state_t    : conversion FSM states (IDLE, CONV, GAP)
//   ADC_DROP_CNT_W : width of the saturating dropped-sample counter
//   adc_chan_width : channel tag width, max(1, clog2(channels))
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    GAP  = 2'd2
  } adc_state_t;

  localparam int ADC_DROP_CNT_W = 16;

  // A single channel still needs a one-bit tag so the port never collapses.
  function automatic int adc_chan_width(input int channels);
    return (channels <= 2) ? 1 : $clog2(channels);
  endfunction

endpackage

// File: rtl/adc_frame_reader_if.sv
// adc_frame_reader_if: ADC pin and sample-stream bundle of the frame reader.
//   en, din, out_ready, ovf_clr        : driven by the environment
//   cs_n, ch_sel                       : ADC chip select and channel mux
//   out_data, out_chan, out_valid      : head of the sample FIFO
//   ovf                                : sticky overflow flag
//   drop_count                         : saturating drop counter, present
//                                        only with ADC_READER_STATUS_EN
// The master modport is the reader itself; slave is the ADC/consumer side.
interface adc_frame_reader_if
  import adc_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int CW    = 1
) ();

  logic             en;
  logic             din;
  logic             cs_n;
  logic [CW-1:0]    ch_sel;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_chan;
  logic             out_valid;
  logic             out_ready;
  logic             ovf;
  logic             ovf_clr;
`ifdef ADC_READER_STATUS_EN
  logic [ADC_DROP_CNT_W-1:0] drop_count;

  modport master (
    input  en, din, out_ready, ovf_clr,
    output cs_n, ch_sel, out_data, out_chan, out_valid, ovf, drop_count
  );

  modport slave (
    output en, din, out_ready, ovf_clr,
    input  cs_n, ch_sel, out_data, out_chan, out_valid, ovf, drop_count
  );
`else
  modport master (
    input  en, din, out_ready, ovf_clr,
    output cs_n, ch_sel, out_data, out_chan, out_valid, ovf
  );

  modport slave (
    output en, din, out_ready, ovf_clr,
    input  cs_n, ch_sel, out_data, out_chan, out_valid, ovf
  );
`endif

endinterface

// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo: synchronous first-word-fall-through FIFO for tagged samples.
//   clk, rst       : clock, asynchronous active-high reset
//   push_i, data_i : write request and word
//   pop_i          : read request (ignored while empty)
//   data_o         : head word, valid whenever empty_o is low
//   full_o/empty_o : occupancy flags
// A push on a full FIFO is accepted only when a pop frees a slot on the same edge.
module adc_sample_fifo #(
  parameter int DW    = 14,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          wr_en;
  logic          rd_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);
  assign data_o  = mem_q[rd_ptr_q];

  // Storage is cleared on reset so the head word reads as zero while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/adc_frame_reader.sv
// adc_frame_reader: serial ADC front end. Frames each conversion with an
// active-low chip select, deserialises WIDTH bits (MSB- or LSB-first), scans
// CHANNELS inputs round-robin and queues {sample, channel} in a small FIFO.
//   clk, rst : bit clock (din sampled on rising edges), async active-high reset
//   bus      : adc_frame_reader_if.master (ADC pins, sample stream, status)
// Build option ADC_READER_STATUS_EN adds the 16-bit saturating drop counter.
module adc_frame_reader
  import adc_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter int CHANNELS   = 1,
  parameter int GAP_CYCLES = 2,
  parameter int MSB_FIRST  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  adc_frame_reader_if.master bus
);

  localparam int              CW       = adc_chan_width(CHANNELS);
  localparam int              BW       = $clog2(WIDTH);
  localparam logic [BW-1:0]   LAST_BIT = BW'(WIDTH - 1);
  localparam logic [7:0]      LAST_GAP = 8'(GAP_CYCLES - 1);
  localparam logic [CW-1:0]   LAST_CH  = CW'(CHANNELS - 1);

  adc_state_t       state_q,   state_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic [WIDTH-1:0] shift_q,   shift_d;
  logic [CW-1:0]    ch_sel_q,  ch_sel_d;
  logic             cs_n_q,    cs_n_d;
  logic             ovf_q,     ovf_d;
  logic             frame_done;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             drop;
  logic [WIDTH+CW-1:0] fifo_dout;

  // Conversion sequencer. The sample handed to the FIFO is shift_d so the
  // bit arriving on the final edge is included.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    shift_d    = shift_q;
    ch_sel_d   = ch_sel_q;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        shift_d   = '0;
        if (bus.en) begin
          state_d = CONV;
        end
      end
      CONV: begin
        if (MSB_FIRST != 0) begin
          shift_d = {shift_q[WIDTH-2:0], bus.din};
        end else begin
          shift_d[bit_cnt_q] = bus.din;
        end
        if (bit_cnt_q == LAST_BIT) begin
          frame_done = 1'b1;
          bit_cnt_d  = '0;
          gap_cnt_d  = '0;
          state_d    = GAP;
          if (CHANNELS == 1 || ch_sel_q == LAST_CH) begin
            ch_sel_d = '0;
          end else begin
            ch_sel_d = ch_sel_q + 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      GAP: begin
        shift_d = '0;
        if (gap_cnt_q == LAST_GAP) begin
          state_d = bus.en ? CONV : IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    cs_n_d = (state_d != CONV);
  end

  // A full FIFO still takes the sample when the consumer pops on that edge.
  always_comb begin
    fifo_pop = !fifo_empty && bus.out_ready;
    drop     = frame_done && fifo_full && !fifo_pop;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State and datapath registers; reset discards any partial sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      shift_q   <= '0;
      ch_sel_q  <= '0;
      cs_n_q    <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      shift_q   <= shift_d;
      ch_sel_q  <= ch_sel_d;
      cs_n_q    <= cs_n_d;
      ovf_q     <= ovf_d;
    end
  end

  adc_sample_fifo #(
    .DW    (WIDTH + CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (frame_done),
    .data_i  ({shift_d, ch_sel_q}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.cs_n      = cs_n_q;
  assign bus.ch_sel    = ch_sel_q;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_dout[WIDTH+CW-1:CW];
  assign bus.out_chan  = fifo_dout[CW-1:0];
  assign bus.ovf       = ovf_q;

`ifdef ADC_READER_STATUS_EN
  logic [ADC_DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of dropped samples; only reset clears it.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != '1) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_adc_frame_reader.sv
// tb_adc_frame_reader: directed scoreboard bench for adc_frame_reader.
// Two readers (MSB-first and LSB-first, CHANNELS=3, FIFO_DEPTH=2) share the
// same pins; expected words are queued as bits are driven and popped as the
// DUTs hand them out. Drop counter checks apply with ADC_READER_STATUS_EN.
module tb_adc_frame_reader;
  import adc_pkg::*;

  localparam int W     = 12;
  localparam int CH    = 3;
  localparam int CWL   = 2;
  localparam int DEPTH = 2;
  localparam int GAPC  = 2;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic din;
  logic outReady;
  logic ovfClr;

  always #5 clk = ~clk;

  adc_frame_reader_if #(.WIDTH(W), .CW(CWL)) vMsb ();
  adc_frame_reader_if #(.WIDTH(W), .CW(CWL)) vLsb ();

  assign vMsb.en        = en;
  assign vMsb.din       = din;
  assign vMsb.out_ready = outReady;
  assign vMsb.ovf_clr   = ovfClr;
  assign vLsb.en        = en;
  assign vLsb.din       = din;
  assign vLsb.out_ready = outReady;
  assign vLsb.ovf_clr   = ovfClr;

  adc_frame_reader #(
    .WIDTH(W), .CHANNELS(CH), .GAP_CYCLES(GAPC), .MSB_FIRST(1), .FIFO_DEPTH(DEPTH)
  ) u_msb (.clk(clk), .rst(rst), .bus(vMsb));

  adc_frame_reader #(
    .WIDTH(W), .CHANNELS(CH), .GAP_CYCLES(GAPC), .MSB_FIRST(0), .FIFO_DEPTH(DEPTH)
  ) u_lsb (.clk(clk), .rst(rst), .bus(vLsb));

  int compared   = 0;
  int mismatched = 0;
  int modelChan  = 0;
  int modelDrops = 0;
  logic [W+CWL-1:0] qMsb[$];
  logic [W+CWL-1:0] qLsb[$];
  logic             prevCsLow = 1'b0;
  logic [CWL-1:0]   prevChSel = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] reverseBits(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  // Called on the falling edge: consume words the DUTs hand out this cycle.
  task automatic checkOutput();
    logic [W+CWL-1:0] expWord;
    if (!rst && vMsb.out_valid && vMsb.out_ready) begin
      if (qMsb.size() == 0) begin
        check("msb_unexpected_word", 32'(vMsb.out_valid), 32'd0);
      end else begin
        expWord = qMsb.pop_front();
        check("msb_data", 32'(vMsb.out_data), 32'(expWord[W+CWL-1:CWL]));
        check("msb_chan", 32'(vMsb.out_chan), 32'(expWord[CWL-1:0]));
      end
    end
    if (!rst && vLsb.out_valid && vLsb.out_ready) begin
      if (qLsb.size() == 0) begin
        check("lsb_unexpected_word", 32'(vLsb.out_valid), 32'd0);
      end else begin
        expWord = qLsb.pop_front();
        check("lsb_data", 32'(vLsb.out_data), 32'(expWord[W+CWL-1:CWL]));
        check("lsb_chan", 32'(vLsb.out_chan), 32'(expWord[CWL-1:0]));
      end
    end
    if (!vMsb.cs_n && prevCsLow) begin
      check("ch_sel_stable_in_conv", 32'(vMsb.ch_sel), 32'(prevChSel));
    end
    prevCsLow = !vMsb.cs_n;
    prevChSel = vMsb.ch_sel;
  endtask

  task automatic stepCycle();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  // Drive one frame of val MSB-first. enDropBit/rstBit >= 0 deassert en or
  // assert rst just before that bit is driven.
  task automatic applyStimulus(input logic [W-1:0] val, input int enDropBit, input int rstBit);
    int waited = 0;
    while (vMsb.cs_n === 1'b1 && waited < 100) begin
      stepCycle();
      waited++;
    end
    check("cs_n_low_at_frame_start", 32'(vMsb.cs_n), 32'd0);
    check("ch_sel_at_frame_start", 32'(vMsb.ch_sel), 32'(modelChan));
    for (int i = 0; i < W; i++) begin
      if (i == rstBit) begin
        rst = 1'b1;
        #1;
        check("rst_cs_n_msb", 32'(vMsb.cs_n), 32'd1);
        check("rst_cs_n_lsb", 32'(vLsb.cs_n), 32'd1);
        check("rst_valid_msb", 32'(vMsb.out_valid), 32'd0);
        check("rst_valid_lsb", 32'(vLsb.out_valid), 32'd0);
        check("rst_ch_sel", 32'(vMsb.ch_sel), 32'd0);
        qMsb.delete();
        qLsb.delete();
        modelChan = 0;
        return;
      end
      check("cs_n_low_msb", 32'(vMsb.cs_n), 32'd0);
      check("cs_n_low_lsb", 32'(vLsb.cs_n), 32'd0);
      if (i == enDropBit) en = 1'b0;
      din = val[W-1-i];
      if (i == W - 1) begin
        check("valid_before_push", 32'(vMsb.out_valid), 32'(qMsb.size() != 0));
        if (qMsb.size() < DEPTH) begin
          qMsb.push_back({val, CWL'(modelChan)});
          qLsb.push_back({reverseBits(val), CWL'(modelChan)});
        end else begin
          modelDrops++;
        end
        modelChan = (modelChan + 1) % CH;
      end
      stepCycle();
    end
    check("cs_n_high_after_frame", 32'(vMsb.cs_n), 32'd1);
    check("valid_after_frame_msb", 32'(vMsb.out_valid), 32'd1);
    check("valid_after_frame_lsb", 32'(vLsb.out_valid), 32'd1);
  endtask

  initial begin
    logic [W+CWL-1:0] head;
    rst = 1'b1; en = 1'b0; din = 1'b0; outReady = 1'b1; ovfClr = 1'b0;
    repeat (3) stepCycle();
    check("reset_cs_n", 32'(vMsb.cs_n), 32'd1);
    check("reset_ch_sel", 32'(vMsb.ch_sel), 32'd0);
    check("reset_valid", 32'(vMsb.out_valid), 32'd0);
    check("reset_data", 32'(vMsb.out_data), 32'd0);
    check("reset_chan", 32'(vMsb.out_chan), 32'd0);
    check("reset_ovf", 32'(vMsb.ovf), 32'd0);
    check("reset_ovf_lsb", 32'(vLsb.ovf), 32'd0);
`ifdef ADC_READER_STATUS_EN
    check("reset_drop_count", 32'(vMsb.drop_count), 32'd0);
`endif
    rst = 1'b0;
    stepCycle();
    stepCycle();
    check("idle_cs_n", 32'(vMsb.cs_n), 32'd1);

    $display("[TB] round-robin frames, consumer ready");
    en = 1'b1;
    applyStimulus(12'hA5C, -1, -1);
    applyStimulus(12'h001, -1, -1);
    applyStimulus(12'h800, -1, -1);
    applyStimulus(12'hFFF, -1, -1);
    applyStimulus(12'h5A3, -1, -1);
    stepCycle();

    $display("[TB] overflow with consumer stalled");
    outReady = 1'b0;
    applyStimulus(12'h1E2, -1, -1);
    applyStimulus(12'h7C4, -1, -1);
    applyStimulus(12'h999, -1, -1);
    applyStimulus(12'h246, -1, -1);
    en = 1'b0;
    check("ovf_set_msb", 32'(vMsb.ovf), 32'd1);
    check("ovf_set_lsb", 32'(vLsb.ovf), 32'd1);
`ifdef ADC_READER_STATUS_EN
    check("drop_count_after_ovf", 32'(vMsb.drop_count), 32'(modelDrops));
`endif
    head = qMsb[0];
    check("held_head_data", 32'(vMsb.out_data), 32'(head[W+CWL-1:CWL]));
    repeat (3) stepCycle();
    check("held_head_data_later", 32'(vMsb.out_data), 32'(head[W+CWL-1:CWL]));
    check("held_head_chan", 32'(vMsb.out_chan), 32'(head[CWL-1:0]));
    ovfClr = 1'b1;
    stepCycle();
    ovfClr = 1'b0;
    check("ovf_cleared", 32'(vMsb.ovf), 32'd0);
`ifdef ADC_READER_STATUS_EN
    check("drop_count_kept", 32'(vMsb.drop_count), 32'(modelDrops));
`endif
    outReady = 1'b1;
    repeat (4) stepCycle();
    check("drained_valid", 32'(vMsb.out_valid), 32'd0);
    check("drained_queue", 32'(qMsb.size() + qLsb.size()), 32'd0);

    $display("[TB] en dropped mid-frame");
    en = 1'b1;
    applyStimulus(12'h3C7, 5, -1);
    for (int i = 0; i < 8; i++) begin
      stepCycle();
      check("idle_after_en_drop_cs_n", 32'(vMsb.cs_n), 32'd1);
    end
    check("idle_after_en_drop_state", 32'(u_msb.state_q), 32'(IDLE));

    $display("[TB] reset mid-frame");
    outReady = 1'b0;
    en = 1'b1;
    applyStimulus(12'h0F0, -1, -1);
    applyStimulus(12'hC3A, -1, 7);
    stepCycle();
    rst = 1'b0;
    outReady = 1'b1;
    applyStimulus(12'h6B1, -1, -1);
    en = 1'b0;
    repeat (3) stepCycle();
    check("final_queue_empty", 32'(qMsb.size() + qLsb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
